// File: rtl/lock_entry_controller.sv
// Keypad lock: buffers BCD digits, checks them against a stored code, grants
// access, locks out after repeated failures and allows re-programming the code.
module lock_entry_controller #(
    parameter int                    DIGITS         = 4,
    parameter logic [4*DIGITS-1:0]   DEFAULT_PASS   = 16'h1234,
    parameter int                    MAX_TRIES      = 3,
    parameter int                    GRANT_CYCLES   = 8,
    parameter int                    LOCKOUT_CYCLES = 16,
    parameter int                    TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       prog_en,
    output logic       access,
    output logic       denied,
    output logic       alarm,
    output logic       pass_updated,
    output logic [2:0] digit_count,
    output logic [1:0] fail_count
);
    localparam int BW   = 4 * DIGITS;
    localparam int TMAX = (GRANT_CYCLES > LOCKOUT_CYCLES)
                        ? ((GRANT_CYCLES > TIMEOUT_CYCLES) ? GRANT_CYCLES : TIMEOUT_CYCLES)
                        : ((LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE, ENTRY, CHECK, GRANT, DENY, LOCKOUT, PROG
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   entry_buf_q, entry_buf_d;
    logic [BW-1:0]   code_q, code_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [1:0]      fail_q, fail_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            pupd_q, pupd_d;

    logic            is_digit, is_enter, is_clear, buf_full;
    logic [2:0]      fail_inc;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_enter = key_valid && (key_code == 4'hA);
    assign is_clear = key_valid && (key_code == 4'hB);
    assign buf_full = (cnt_q == 3'(DIGITS));
    assign fail_inc = {1'b0, fail_q} + 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            entry_buf_q <= '0;
            code_q      <= DEFAULT_PASS;
            cnt_q       <= '0;
            fail_q      <= '0;
            timer_q     <= '0;
            pupd_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_buf_q <= entry_buf_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
            fail_q      <= fail_d;
            timer_q     <= timer_d;
            pupd_q      <= pupd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        entry_buf_d = entry_buf_q;
        code_d      = code_q;
        cnt_d       = cnt_q;
        fail_d      = fail_q;
        timer_d     = timer_q;
        pupd_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_digit) begin
                    entry_buf_d = BW'(key_code);
                    cnt_d       = 3'd1;
                    timer_d     = TW'(TIMEOUT_CYCLES - 1);
                    state_d     = ENTRY;
                end
            end
            ENTRY, PROG: begin
                // A key always wins over a timeout expiring in the same cycle
                if (key_valid) begin
                    timer_d = TW'(TIMEOUT_CYCLES - 1);
                    if (is_digit && !buf_full) begin
                        entry_buf_d = {entry_buf_q[BW-5:0], key_code};
                        cnt_d       = cnt_q + 3'd1;
                    end else if (is_clear) begin
                        entry_buf_d = '0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else if (is_enter) begin
                        if (state_q == ENTRY) begin
                            state_d = CHECK;
                        end else begin
                            if (buf_full) begin
                                code_d = entry_buf_q;
                                pupd_d = 1'b1;
                            end
                            entry_buf_d = '0;
                            cnt_d       = '0;
                            state_d     = IDLE;
                        end
                    end
                end else if (timer_q == '0) begin
                    entry_buf_d = '0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            CHECK: begin
                entry_buf_d = '0;
                cnt_d       = '0;
                if (buf_full && entry_buf_q == code_q) begin
                    fail_d  = '0;
                    timer_d = TW'(GRANT_CYCLES - 1);
                    state_d = GRANT;
                end else begin
                    fail_d = fail_inc[1:0];
                    if (fail_inc >= 3'(MAX_TRIES)) begin
                        timer_d = TW'(LOCKOUT_CYCLES - 1);
                        state_d = LOCKOUT;
                    end else begin
                        state_d = DENY;
                    end
                end
            end
            GRANT: begin
                if (is_enter && prog_en) begin
                    timer_d = TW'(TIMEOUT_CYCLES - 1);
                    state_d = PROG;
                end else if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DENY: state_d = IDLE;
            LOCKOUT: begin
                if (timer_q == '0) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign access       = (state_q == GRANT) || (state_q == PROG);
    assign denied       = (state_q == DENY);
    assign alarm        = (state_q == LOCKOUT);
    assign pass_updated = pupd_q;
    assign digit_count  = cnt_q;
    assign fail_count   = fail_q;
endmodule

// File: tb/tb_lock_entry_controller.sv
// Directed bench for lock_entry_controller: grant, deny, lockout, programming,
// timeout and asynchronous reset behaviour with hand-computed expectations.
module tb_lock_entry_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       prog_en = 1'b0;
    logic       access, denied, alarm, pass_updated;
    logic [2:0] digit_count;
    logic [1:0] fail_count;

    int checks = 0;
    int errors = 0;

    lock_entry_controller dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .prog_en(prog_en), .access(access), .denied(denied), .alarm(alarm),
        .pass_updated(pass_updated), .digit_count(digit_count), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Key is sampled at the posedge between the two negedges; returns on the negedge after it
    task automatic key(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic keys4(input logic [3:0] a, b, c, d);
        key(a); key(b); key(c); key(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Count consecutive negedges with access high, starting now
    task automatic count_access(output int n);
        n = 0;
        while (access && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Called right after enter: expect one CHECK cycle then a DENY pulse
    task automatic expect_deny(input string tag);
        check({tag, "_chk"}, denied, 0);
        @(negedge clk);
        check({tag, "_den"}, denied, 1);
        @(negedge clk);
        check({tag, "_den_off"}, denied, 0);
    endtask

    int n;

    initial begin
        // Reset state
        #3;
        check("rst_access", access, 0);
        check("rst_alarm", alarm, 0);
        check("rst_dcnt", digit_count, 0);
        check("rst_fcnt", fail_count, 0);
        @(negedge clk);
        reset = 1'b1;

        // Ignored keys in IDLE
        key(4'hC); key(4'hA); key(4'hB);
        check("idle_ignore", digit_count, 0);

        // Correct code: access for 8 cycles, 2 edges after enter
        keys4(4'd1, 4'd2, 4'd3, 4'd4);
        check("dcnt4", digit_count, 4);
        key(4'hA);
        check("grant_lat", access, 0);
        @(negedge clk);
        count_access(n);
        check("grant_len", n, 8);
        check("grant_fcnt", fail_count, 0);

        // Clear in ENTRY
        key(4'd1); key(4'd2);
        check("clr_pre", digit_count, 2);
        key(4'hB);
        check("clr_dcnt", digit_count, 0);

        // Three wrong codes -> two denies then lockout
        keys4(4'd1, 4'd2, 4'd3, 4'd5); key(4'hA);
        expect_deny("wrong1");
        check("wrong1_fcnt", fail_count, 1);
        keys4(4'd1, 4'd2, 4'd3, 4'd5); key(4'hA);
        expect_deny("wrong2");
        check("wrong2_fcnt", fail_count, 2);
        keys4(4'd1, 4'd2, 4'd3, 4'd5); key(4'hA);
        @(negedge clk);
        check("lock_nodeny", denied, 0);
        n = 0;
        while (alarm && n < 100) begin
            n++;
            key_valid = 1'b1;
            key_code  = 4'd1;
            @(negedge clk);
        end
        key_valid = 1'b0;
        check("lock_len", n, 16);
        check("lock_fcnt", fail_count, 0);
        check("lock_keys_ignored", digit_count, 0);

        // Short code denied, then extra digit discarded and granted
        key(4'd1); key(4'd2); key(4'd3); key(4'hA);
        expect_deny("short");
        check("short_fcnt", fail_count, 1);
        keys4(4'd1, 4'd2, 4'd3, 4'd4); key(4'd5);
        check("sat_dcnt", digit_count, 4);
        key(4'hA);
        @(negedge clk);
        check("sat_grant", access, 1);
        check("sat_fcnt", fail_count, 0);

        // Reprogram to 9876 while granted
        prog_en = 1'b1;
        key(4'hA);
        prog_en = 1'b0;
        check("prog_access", access, 1);
        idle(10);
        check("prog_hold", access, 1);
        keys4(4'd9, 4'd8, 4'd7, 4'd6); key(4'hA);
        check("pupd", pass_updated, 1);
        check("pupd_access", access, 0);
        @(negedge clk);
        check("pupd_off", pass_updated, 0);
        keys4(4'd1, 4'd2, 4'd3, 4'd4); key(4'hA);
        expect_deny("old_code");
        keys4(4'd9, 4'd8, 4'd7, 4'd6); key(4'hA);
        @(negedge clk);
        count_access(n);
        check("new_code_len", n, 8);

        // Inactivity timeout keeps fail_count
        key(4'd1); key(4'hA);
        expect_deny("to_pre");
        key(4'd1); key(4'd2);
        idle(63);
        check("to_before", digit_count, 2);
        @(negedge clk);
        check("to_after", digit_count, 0);
        check("to_fcnt", fail_count, 1);
        key(4'd1);
        check("to_idle_restart", digit_count, 1);
        key(4'hB);

        // Reach lockout, then async reset restores 1234
        key(4'd5); key(4'hA);
        expect_deny("to_lock1");
        key(4'd5); key(4'hA);
        @(negedge clk);
        check("rst_lock_alarm", alarm, 1);
        idle(3);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_alarm", alarm, 0);
        check("rst_mid_fcnt", fail_count, 0);
        @(negedge clk);
        reset = 1'b1;
        keys4(4'd1, 4'd2, 4'd3, 4'd4); key(4'hA);
        @(negedge clk);
        count_access(n);
        check("rst_code_len", n, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lock_entry_controller.md
LOCK_ENTRY_CONTROLLER -- requirements
Module: lock_entry_controller

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning number of BCD digits in a code.
REQ-002 SHALL have parameter DEFAULT_PASS, default 16'h1234, meaning the BCD code loaded at reset.
REQ-003 SHALL have parameter MAX_TRIES, default 3, meaning consecutive failures that trigger lockout.
REQ-004 SHALL have parameter GRANT_CYCLES, default 8, meaning access hold time in clocks.
REQ-005 SHALL have parameter LOCKOUT_CYCLES, default 16, meaning alarm/lockout duration in clocks.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning inactivity limit during entry or programming.
REQ-007 SHALL have clk  input  1  sole clock, rising edge.
REQ-008 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have key_valid  input  1  one-cycle key strobe.
REQ-010 SHALL have key_code  input  4  0-9 digit, 4'hA enter, 4'hB clear, 4'hC-F ignored.
REQ-011 SHALL have prog_en  input  1  level; requests password change at an enter key in GRANT.
REQ-012 SHALL have access  output  1  high while in GRANT or PROG.
REQ-013 SHALL have denied  output  1  one-cycle pulse on a failed, non-locking check.
REQ-014 SHALL have alarm  output  1  high while in LOCKOUT.
REQ-015 SHALL have pass_updated  output  1  one-cycle pulse when a new code is stored.
REQ-016 SHALL have digit_count  output  3  digits currently buffered (saturates at DIGITS).
REQ-017 SHALL have fail_count  output  2  consecutive failed checks.

Function
REQ-018 SHALL implement states IDLE, ENTRY, CHECK, GRANT, DENY, LOCKOUT, PROG; all outputs are decoded from registered state/counters (Moore).
REQ-019 SHALL, in IDLE, on a digit key load it as the first buffered digit, set digit_count=1, go to ENTRY; enter, clear and 4'hC-F are ignored.
REQ-020 SHALL, in ENTRY/PROG, shift each digit into the low nibble of a 4*DIGITS-bit buffer while digit_count<DIGITS; further digits are discarded, with no shift and no count change.
REQ-021 SHALL, in ENTRY, on clear zero the buffer and digit_count and go to IDLE; fail_count is unchanged.
REQ-022 SHALL, in ENTRY, on enter go to CHECK the next cycle.
REQ-023 SHALL, in CHECK (one cycle), treat match as digit_count==DIGITS and buffer==stored code.
REQ-024 SHALL, on match, clear fail_count and go to GRANT.
REQ-025 SHALL, on mismatch, increment fail_count; at MAX_TRIES go to LOCKOUT, else go to DENY.
REQ-026 SHALL clear the buffer and digit_count on every exit from CHECK.
REQ-027 SHALL hold access=1 for exactly GRANT_CYCLES clocks in GRANT, then return to IDLE.
REQ-028 SHALL, in GRANT, on enter with prog_en=1 go to PROG; access stays high and the grant timer is abandoned; other keys in GRANT are ignored.
REQ-029 SHALL, in PROG on enter: with digit_count==DIGITS write the buffer to the stored code, pulse pass_updated, go to IDLE; otherwise go to IDLE with the code unchanged.
REQ-030 SHALL, in PROG on clear, go to IDLE with the code unchanged.
REQ-031 SHALL, in DENY (one cycle), assert denied, then go to IDLE.
REQ-032 SHALL, in LOCKOUT, ignore all keys, hold alarm=1 for exactly LOCKOUT_CYCLES clocks, then clear fail_count and go to IDLE.
REQ-033 SHALL reload the inactivity counter on every key_valid in ENTRY/PROG.
REQ-034 SHALL, after TIMEOUT_CYCLES clocks without key_valid in ENTRY/PROG, clear the buffer and go to IDLE; this is not a failure and fail_count is unchanged.
REQ-035 SHALL fix latency: enter sampled at edge N gives CHECK after N, and GRANT/DENY/LOCKOUT outputs visible after edge N+1.
REQ-036 SHALL give key_valid priority over an expiring timeout in the same cycle.

Reset
REQ-037 SHALL, on reset low, immediately force IDLE, clear buffer, digit_count, fail_count and all timers, and set access=denied=alarm=pass_updated=0.
REQ-038 SHALL reload the stored code to DEFAULT_PASS on reset, including reset asserted mid-GRANT, mid-PROG or mid-LOCKOUT.

Verification
REQ-039 Keys 1,2,3,4,enter after reset -> access high 8 cycles starting 2 edges after enter; fail_count=0.
REQ-040 Keys 1,2,3,5,enter three times -> denied pulses twice; third sets alarm=1 for 16 cycles, keys ignored, then fail_count=0.
REQ-041 Keys 1,2,3,enter -> denied pulse, fail_count=1; keys 1,2,3,4,5,enter -> fifth digit discarded, access granted.
REQ-042 Grant, enter with prog_en=1, keys 9,8,7,6,enter -> pass_updated pulse; 1,2,3,4 then denied; 9,8,7,6 then granted.
REQ-043 Keys 1,2 then 64 idle cycles -> IDLE, digit_count=0, fail_count unchanged; reset low during LOCKOUT -> alarm=0 immediately, code back to 1234.
